// File: rtl/nco_bank.sv
// Bank of time-multiplexed numerically controlled oscillators. A sample_clk_en
// pulse sweeps channels 0..N-1, emitting one registered sample per cycle.
module nco_bank #(
    parameter int NUM_CHANNELS    = 4,
    parameter int PHASE_ACC_WIDTH = 20,
    parameter int OUTPUT_WIDTH    = 16,
    parameter int FNUM_WIDTH      = 10,
    parameter int MULT_WIDTH      = 4,
    parameter int BLOCK_WIDTH     = 3,
    parameter int WS_WIDTH        = 2,
    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_clk_en,
    input  logic                           wr_en,
    input  logic [CHAN_W-1:0]              wr_chan,
    input  logic [FNUM_WIDTH-1:0]          wr_fnum,
    input  logic [MULT_WIDTH-1:0]          wr_mult,
    input  logic [BLOCK_WIDTH-1:0]         wr_block,
    input  logic [WS_WIDTH-1:0]            wr_ws,
    input  logic                           wr_key_on,
    output logic                           out_valid,
    output logic [CHAN_W-1:0]              out_chan,
    output logic signed [OUTPUT_WIDTH-1:0] out_sample,
    output logic                           busy,
    output logic                           overrun
);

    localparam int W      = OUTPUT_WIDTH;
    localparam int PROD_W = FNUM_WIDTH + (1 << BLOCK_WIDTH) + MULT_WIDTH + 1;
    localparam int CALC_W = (PROD_W > PHASE_ACC_WIDTH + 2) ? PROD_W : PHASE_ACC_WIDTH + 2;
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHANNELS - 1);

    logic [FNUM_WIDTH-1:0]      fnum_q  [NUM_CHANNELS];
    logic [FNUM_WIDTH-1:0]      fnum_d  [NUM_CHANNELS];
    logic [MULT_WIDTH-1:0]      mult_q  [NUM_CHANNELS];
    logic [MULT_WIDTH-1:0]      mult_d  [NUM_CHANNELS];
    logic [BLOCK_WIDTH-1:0]     block_q [NUM_CHANNELS];
    logic [BLOCK_WIDTH-1:0]     block_d [NUM_CHANNELS];
    logic [WS_WIDTH-1:0]        ws_q    [NUM_CHANNELS];
    logic [WS_WIDTH-1:0]        ws_d    [NUM_CHANNELS];
    logic                       key_on_q[NUM_CHANNELS];
    logic                       key_on_d[NUM_CHANNELS];
    logic [PHASE_ACC_WIDTH-1:0] acc_q   [NUM_CHANNELS];
    logic [PHASE_ACC_WIDTH-1:0] acc_d   [NUM_CHANNELS];

    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [CHAN_W-1:0] out_chan_q, out_chan_d;
    logic signed [W-1:0] out_sample_q, out_sample_d;

    logic              proc_en;
    logic [CHAN_W-1:0] proc_chan;

    // Full-width product, then drop the two fractional bits and wrap to the accumulator.
    function automatic logic [PHASE_ACC_WIDTH-1:0] phase_inc(
        input logic [FNUM_WIDTH-1:0]  fnum,
        input logic [MULT_WIDTH-1:0]  mult,
        input logic [BLOCK_WIDTH-1:0] blk
    );
        logic [CALC_W-1:0] shifted;
        logic [CALC_W-1:0] m2;
        shifted = CALC_W'(fnum) << blk;
        m2      = (mult == '0) ? CALC_W'(1) : (CALC_W'(mult) << 1);
        return PHASE_ACC_WIDTH'((shifted * m2) >> 2);
    endfunction

    // Subtracting H from a W-bit unsigned value is an MSB flip in two's complement.
    function automatic logic [W-1:0] waveform(
        input logic [W-1:0]        p,
        input logic [WS_WIDTH-1:0] ws
    );
        logic [W-2:0] q;
        logic [W-1:0] r;
        r = '0;
        q = p[W-1] ? ~p[W-2:0] : p[W-2:0];
        if (ws == WS_WIDTH'(0)) begin
            r = {~p[W-1], p[W-2:0]};
        end else if (ws == WS_WIDTH'(1)) begin
            r = p[W-1] ? {1'b1, {(W-2){1'b0}}, 1'b1} : {1'b0, {(W-1){1'b1}}};
        end else if (ws == WS_WIDTH'(2)) begin
            r = {q, 1'b0};
            r[W-1] = ~r[W-1];
        end
        return r;
    endfunction

    always_comb begin
        fnum_d       = fnum_q;
        mult_d       = mult_q;
        block_d      = block_q;
        ws_d         = ws_q;
        key_on_d     = key_on_q;
        acc_d        = acc_q;
        out_chan_d   = '0;
        out_sample_d = '0;
        overrun_d    = overrun_q | (sample_clk_en & busy_q);
        proc_en      = 1'b0;
        proc_chan    = '0;

        if (sample_clk_en && !busy_q) begin
            proc_en = 1'b1;
        end else if (busy_q && out_chan_q != LAST_CHAN) begin
            proc_en   = 1'b1;
            proc_chan = out_chan_q + 1'b1;
        end
        busy_d = proc_en;

        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (!key_on_q[i]) begin
                acc_d[i] = '0;
            end
        end

        // The sample and accumulator step use pre-edge fields, so a coincident write only affects later sweeps.
        if (proc_en && key_on_q[proc_chan]) begin
            out_sample_d     = waveform(acc_q[proc_chan][PHASE_ACC_WIDTH-1 -: W], ws_q[proc_chan]);
            acc_d[proc_chan] = acc_q[proc_chan]
                             + phase_inc(fnum_q[proc_chan], mult_q[proc_chan], block_q[proc_chan]);
        end
        if (proc_en) begin
            out_chan_d = proc_chan;
        end

        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (wr_en && wr_chan == CHAN_W'(i)) begin
                fnum_d[i]   = wr_fnum;
                mult_d[i]   = wr_mult;
                block_d[i]  = wr_block;
                ws_d[i]     = wr_ws;
                key_on_d[i] = wr_key_on;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fnum_q       <= '{default: '0};
            mult_q       <= '{default: '0};
            block_q      <= '{default: '0};
            ws_q         <= '{default: '0};
            key_on_q     <= '{default: 1'b0};
            acc_q        <= '{default: '0};
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            out_chan_q   <= '0;
            out_sample_q <= '0;
        end else begin
            fnum_q       <= fnum_d;
            mult_q       <= mult_d;
            block_q      <= block_d;
            ws_q         <= ws_d;
            key_on_q     <= key_on_d;
            acc_q        <= acc_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            out_chan_q   <= out_chan_d;
            out_sample_q <= out_sample_d;
        end
    end

    assign busy       = busy_q;
    assign out_valid  = busy_q;
    assign out_chan   = out_chan_q;
    assign out_sample = out_sample_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_nco_bank.sv
// Self-checking bench for nco_bank: directed known answers, overrun, reset
// abort, coincident writes and randomized sweeps against an arithmetic model.
module tb_nco_bank;

    localparam int N   = 4;
    localparam int PAW = 20;
    localparam int W   = 16;
    localparam int H   = 32768;
    localparam longint MASK = (64'd1 << PAW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_clk_en;
    logic              wr_en;
    logic [1:0]        wr_chan;
    logic [9:0]        wr_fnum;
    logic [3:0]        wr_mult;
    logic [2:0]        wr_block;
    logic [1:0]        wr_ws;
    logic              wr_key_on;
    logic              out_valid;
    logic [1:0]        out_chan;
    logic signed [15:0] out_sample;
    logic              busy;
    logic              overrun;

    int total = 0;
    int bad   = 0;

    int     m_fnum [N];
    int     m_mult [N];
    int     m_block[N];
    int     m_ws   [N];
    int     m_key  [N];
    longint m_phase[N];
    int     last_obs[N];

    nco_bank #(
        .NUM_CHANNELS   (N),
        .PHASE_ACC_WIDTH(PAW),
        .OUTPUT_WIDTH   (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_clk_en(sample_clk_en),
        .wr_en        (wr_en),
        .wr_chan      (wr_chan),
        .wr_fnum      (wr_fnum),
        .wr_mult      (wr_mult),
        .wr_block     (wr_block),
        .wr_ws        (wr_ws),
        .wr_key_on    (wr_key_on),
        .out_valid    (out_valid),
        .out_chan     (out_chan),
        .out_sample   (out_sample),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_fnum[i] = 0; m_mult[i] = 0; m_block[i] = 0;
            m_ws[i] = 0; m_key[i] = 0; m_phase[i] = 0;
        end
    endtask

    task automatic model_write(input int ch, input int f, input int m, input int b,
                               input int ws, input int key);
        m_fnum[ch] = f; m_mult[ch] = m; m_block[ch] = b; m_ws[ch] = ws; m_key[ch] = key;
        if (key == 0) m_phase[ch] = 0;
    endtask

    // Expected sample from the current phase, then advance the phase.
    function automatic int model_step(input int ch);
        longint p, inc, m2;
        int s, q;
        if (m_key[ch] == 0) begin
            m_phase[ch] = 0;
            return 0;
        end
        p = m_phase[ch] >> (PAW - W);
        case (m_ws[ch])
            0: s = int'(p) - H;
            1: s = (p < H) ? H - 1 : -(H - 1);
            2: begin
                q = (p < H) ? int'(p) : (H - 1) - (int'(p) - H);
                s = 2 * q - H;
            end
            default: s = 0;
        endcase
        m2  = (m_mult[ch] == 0) ? 1 : 2 * m_mult[ch];
        inc = (((longint'(m_fnum[ch]) << m_block[ch]) * m2) >> 2) & MASK;
        m_phase[ch] = (m_phase[ch] + inc) & MASK;
        return s;
    endfunction

    task automatic do_write(input int ch, input int f, input int m, input int b,
                            input int ws, input int key);
        wr_en = 1'b1; wr_chan = 2'(ch); wr_fnum = 10'(f); wr_mult = 4'(m);
        wr_block = 3'(b); wr_ws = 2'(ws); wr_key_on = key[0];
        step();
        wr_en = 1'b0;
        model_write(ch, f, m, b, ws, key);
    endtask

    // One full sweep; optionally a write to ch0 coincident with the start edge.
    task automatic run_sweep(input string name, input bit with_wr, input int f, input int m,
                             input int b, input int ws, input int key);
        int e;
        sample_clk_en = 1'b1;
        if (with_wr) begin
            wr_en = 1'b1; wr_chan = 2'd0; wr_fnum = 10'(f); wr_mult = 4'(m);
            wr_block = 3'(b); wr_ws = 2'(ws); wr_key_on = key[0];
        end
        step();
        sample_clk_en = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            e = model_step(k);
            if (k == 0 && with_wr) model_write(0, f, m, b, ws, key);
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL %s valid/busy ch%0d: got %b/%b want 1/1", name, k, out_valid, busy);
            end
            total++;
            if (out_chan !== 2'(k)) begin
                bad++;
                $display("FAIL %s out_chan: got %0d want %0d", name, out_chan, k);
            end
            total++;
            if (out_sample !== 16'(e)) begin
                bad++;
                $display("FAIL %s sample ch%0d: got %0d want %0d", name, k, out_sample, e);
            end
            last_obs[k] = int'(out_sample);
            if (k < N - 1) step();
        end
        step();
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_chan !== 2'd0 || out_sample !== 16'sd0) begin
            bad++;
            $display("FAIL %s idle after sweep: busy=%b valid=%b chan=%0d sample=%0d want 0/0/0/0",
                     name, busy, out_valid, out_chan, out_sample);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sample_clk_en = 1'b0; wr_en = 1'b0; wr_chan = '0;
        wr_fnum = '0; wr_mult = '0; wr_block = '0; wr_ws = '0; wr_key_on = 1'b0;
        step(); step();
        reset = 1'b0;
        model_clear();
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_chan !== 2'd0 ||
            out_sample !== 16'sd0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b valid=%b chan=%0d sample=%0d ovr=%b want all 0",
                     busy, out_valid, out_chan, out_sample, overrun);
        end
        run_sweep("reset_sweep", 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_known_answers();
        int ch0_exp[3] = '{-32768, -32512, -32256};
        int ch1_exp[3] = '{32767, -32767, -32767};
        do_write(0, 512, 1, 4, 0, 1);
        do_write(1, 1023, 15, 7, 1, 1);
        do_write(2, 4, 0, 0, 2, 1);
        do_write(3, 300, 3, 5, 0, 0);
        for (int s = 0; s < 3; s++) begin
            run_sweep("known", 1'b0, 0, 0, 0, 0, 0);
            total++;
            if (last_obs[0] != ch0_exp[s]) begin
                bad++;
                $display("FAIL known_ch0 sweep%0d: got %0d want %0d", s, last_obs[0], ch0_exp[s]);
            end
            total++;
            if (last_obs[1] != ch1_exp[s]) begin
                bad++;
                $display("FAIL known_ch1 sweep%0d: got %0d want %0d", s, last_obs[1], ch1_exp[s]);
            end
            total++;
            if (last_obs[3] != 0) begin
                bad++;
                $display("FAIL keyoff_ch3 sweep%0d: got %0d want 0", s, last_obs[3]);
            end
        end
    endtask

    task automatic test_overrun();
        int valids = 0;
        int e;
        sample_clk_en = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            sample_clk_en = (c == 2);
            total++;
            if (busy !== (c <= 4) || out_valid !== (c <= 4)) begin
                bad++;
                $display("FAIL overrun_busy cycle t+%0d: busy=%b valid=%b want %b", c, busy, out_valid, c <= 4);
            end
            total++;
            if (overrun !== (c >= 3)) begin
                bad++;
                $display("FAIL overrun_flag cycle t+%0d: got %b want %b", c, overrun, c >= 3);
            end
            if (c <= 4) begin
                e = model_step(c - 1);
                total++;
                if (out_chan !== 2'(c - 1) || out_sample !== 16'(e)) begin
                    bad++;
                    $display("FAIL overrun_sample t+%0d: chan=%0d sample=%0d want %0d/%0d",
                             c, out_chan, out_sample, c - 1, e);
                end
            end
            if (out_valid === 1'b1) valids++;
            step();
        end
        sample_clk_en = 1'b0;
        total++;
        if (valids != 4) begin
            bad++;
            $display("FAIL overrun_valid_count: got %0d want 4", valids);
        end
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky: got %b want 1", overrun);
        end
    endtask

    task automatic test_same_cycle_write();
        run_sweep("same_cycle_wr", 1'b1, 100, 2, 6, 2, 1);
        run_sweep("after_wr", 1'b0, 0, 0, 0, 0, 0);
        run_sweep("after_wr2", 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_sweep();
        int e;
        sample_clk_en = 1'b1;
        step();
        sample_clk_en = 1'b0;
        e = model_step(0);
        total++;
        if (out_valid !== 1'b1 || out_sample !== 16'(e)) begin
            bad++;
            $display("FAIL midreset_first: valid=%b sample=%0d want 1/%0d", out_valid, out_sample, e);
        end
        step();
        reset = 1'b1; sample_clk_en = 1'b1;
        wr_en = 1'b1; wr_chan = 2'd1; wr_fnum = 10'd700; wr_mult = 4'd5;
        wr_block = 3'd6; wr_ws = 2'd1; wr_key_on = 1'b1;
        step();
        reset = 1'b0; sample_clk_en = 1'b0; wr_en = 1'b0;
        model_clear();
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_chan !== 2'd0 ||
            out_sample !== 16'sd0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL midreset_abort: busy=%b valid=%b chan=%0d sample=%0d ovr=%b want all 0",
                     busy, out_valid, out_chan, out_sample, overrun);
        end
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_no_start: busy=%b want 0", busy);
        end
        run_sweep("post_reset", 1'b0, 0, 0, 0, 0, 0);
        for (int k = 0; k < N; k++) begin
            total++;
            if (last_obs[k] != 0) begin
                bad++;
                $display("FAIL post_reset_zero ch%0d: got %0d want 0", k, last_obs[k]);
            end
        end
    endtask

    task automatic test_random();
        int nw, idle;
        for (int it = 0; it < 25; it++) begin
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                do_write($urandom_range(0, N - 1), $urandom_range(0, 1023), $urandom_range(0, 15),
                         $urandom_range(0, 7), $urandom_range(0, 3),
                         ($urandom_range(0, 3) != 0) ? 1 : 0);
            end
            idle = $urandom_range(0, 2);
            for (int i = 0; i < idle; i++) step();
            if ($urandom_range(0, 4) == 0)
                run_sweep("random_wr", 1'b1, $urandom_range(0, 1023), $urandom_range(0, 15),
                          $urandom_range(0, 7), $urandom_range(0, 3), 1);
            else
                run_sweep("random", 1'b0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_known_answers();
        test_overrun();
        test_same_cycle_write();
        test_reset_mid_sweep();
        test_known_answers();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
